// File: rtl/accum_alu_stack.sv
// Push-button accumulator ALU with carry/zero flags, optional saturation
// and a bounded undo history.
module accum_alu_stack #(
  parameter int ACC_W = 8,
  parameter int IN_W  = 3,
  parameter int DEPTH = 4,
  parameter int SAT   = 0,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             undo,
  input  logic [IN_W-1:0]  in,
  input  logic [2:0]       op,
  output logic [ACC_W-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic [CW-1:0]    hist_cnt
);

  logic             r_en_q;
  logic             r_undo_q;
  logic [ACC_W-1:0] r_out;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [ACC_W-1:0] r_hist [DEPTH];

  logic             w_commit;
  logic             w_undo;
  logic [ACC_W-1:0] w_b;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W:0]   w_dif;
  logic [ACC_W-1:0] w_res;
  logic             w_cy;
  logic             w_has;
  logic             w_full;

  assign w_commit = en & ~r_en_q;
  assign w_undo   = undo & ~r_undo_q;
  assign w_b      = ACC_W'(in);
  assign w_sum    = {1'b0, r_out} + {1'b0, w_b};
  assign w_dif    = {1'b0, r_out} - {1'b0, w_b};
  assign w_has    = (r_cnt != '0);
  assign w_full   = (r_cnt == CW'(DEPTH));

  always_comb begin
    w_res = r_out;
    w_cy  = 1'b0;
    unique case (op)
      3'b000: begin
        w_cy  = w_sum[ACC_W];
        w_res = w_sum[ACC_W-1:0];
        if (SAT != 0 && w_cy) w_res = '1;
      end
      3'b001: begin
        w_cy  = w_dif[ACC_W];
        w_res = w_dif[ACC_W-1:0];
        if (SAT != 0 && w_cy) w_res = '0;
      end
      3'b010: w_res = r_out ^ w_b;
      // Shifts of ACC_W or more naturally clear the result.
      3'b011: w_res = r_out << in;
      3'b100: w_res = r_out >> in;
      3'b101: w_res = r_out & w_b;
      3'b110: w_res = r_out | w_b;
      3'b111: w_res = w_b;
      default: w_res = r_out;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_en_q   <= 1'b0;
      r_undo_q <= 1'b0;
      r_out    <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_en_q   <= en;
      r_undo_q <= undo;
      if (w_undo) begin
        if (w_has) begin
          r_out   <= r_hist[0];
          r_cnt   <= r_cnt - 1'b1;
          r_carry <= 1'b0;
        end
      end else if (w_commit) begin
        r_out   <= w_res;
        r_carry <= w_cy;
        if (!w_full) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Entry 0 is the newest; a push past DEPTH falls off the far end.
  always_ff @(posedge clock) begin
    if (w_undo) begin
      if (w_has) begin
        for (int i = 0; i < DEPTH - 1; i++) r_hist[i] <= r_hist[i+1];
      end
    end else if (w_commit) begin
      r_hist[0] <= r_out;
      for (int i = 1; i < DEPTH; i++) r_hist[i] <= r_hist[i-1];
    end
  end

  assign out      = r_out;
  assign carry    = r_carry;
  assign zero     = (r_out == '0);
  assign hist_cnt = r_cnt;

endmodule

// File: tb/tb_accum_alu_stack.sv
// Directed bench for accum_alu_stack: wrap-mode and saturating instances
// driven from the same inputs.
module tb_accum_alu_stack;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       en    = 1'b0;
  logic       undo  = 1'b0;
  logic [2:0] in    = '0;
  logic [2:0] op    = '0;

  logic [7:0] out0, out1;
  logic       carry0, carry1, zero0, zero1;
  logic [2:0] hc0, hc1;

  int ncmp  = 0;
  int nfail = 0;

  accum_alu_stack #(.ACC_W(8), .IN_W(3), .DEPTH(4), .SAT(0)) d0 (
    .clock(clock), .reset(reset), .en(en), .undo(undo),
    .in(in), .op(op), .out(out0), .carry(carry0),
    .zero(zero0), .hist_cnt(hc0)
  );

  accum_alu_stack #(.ACC_W(8), .IN_W(3), .DEPTH(4), .SAT(1)) d1 (
    .clock(clock), .reset(reset), .en(en), .undo(undo),
    .in(in), .op(op), .out(out1), .carry(carry1),
    .zero(zero1), .hist_cnt(hc1)
  );

  always #5 clock = ~clock;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, XOR = 3'd2;
  localparam logic [2:0] SHL = 3'd3, SHR = 3'd4, AND = 3'd5;
  localparam logic [2:0] OR  = 3'd6, LD  = 3'd7;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [2:0] o, input logic [2:0] v);
    @(negedge clock);
    op = o;
    in = v;
    en = 1'b1;
    @(negedge clock);
    en = 1'b0;
  endtask

  task automatic pundo();
    @(negedge clock);
    undo = 1'b1;
    @(negedge clock);
    undo = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_out", out0, 0);
    chk("rst_carry", carry0, 0);
    chk("rst_zero", zero0, 1);
    chk("rst_hist", hc0, 0);
    reset = 1'b0;

    press(LD, 5);
    chk("ld5", out0, 5);
    chk("ld5_zero", zero0, 0);
    press(ADD, 7);
    chk("add7", out0, 12);
    chk("add7_c", carry0, 0);
    press(SUB, 7);
    chk("sub7a", out0, 5);
    press(SUB, 7);
    chk("sub7b", out0, 254);
    chk("sub7b_c", carry0, 1);

    @(negedge clock);
    op = ADD;
    in = 1;
    en = 1'b1;
    repeat (10) @(negedge clock);
    en = 1'b0;
    chk("hold_once", out0, 255);
    chk("hold_c", carry0, 0);

    press(LD, 3);
    press(SHL, 7);
    chk("shl7", out0, 128);
    press(SHL, 1);
    chk("shl1", out0, 0);
    chk("shl1_zero", zero0, 1);
    press(LD, 7);
    press(SHR, 2);
    chk("shr2", out0, 1);
    press(XOR, 5);
    chk("xor5", out0, 4);
    press(AND, 6);
    chk("and6", out0, 4);
    press(OR, 3);
    chk("or3", out0, 7);

    press(LD, 7);
    repeat (35) press(ADD, 7);
    chk("sat_252", out1, 252);
    press(ADD, 7);
    chk("sat_add", out1, 255);
    chk("sat_add_c", carry1, 1);
    chk("wrap_add", out0, 3);
    chk("wrap_add_c", carry0, 1);
    press(LD, 2);
    press(SUB, 5);
    chk("sat_sub", out1, 0);
    chk("sat_sub_c", carry1, 1);
    chk("wrap_sub", out0, 253);
    chk("wrap_sub_c", carry0, 1);

    press(LD, 1);
    repeat (4) press(ADD, 1);
    chk("u_pre", out0, 5);
    chk("u_pre_h", hc0, 4);
    pundo();
    chk("u1", out0, 4);
    chk("u1_c", carry0, 0);
    chk("u1_h", hc0, 3);
    pundo();
    chk("u2", out0, 3);
    pundo();
    chk("u3", out0, 2);
    pundo();
    chk("u4", out0, 1);
    chk("u4_h", hc0, 0);
    pundo();
    chk("u5", out0, 1);
    chk("u5_h", hc0, 0);
    chk("u5_sat", out1, 1);

    press(LD, 1);
    press(ADD, 1);
    chk("both_pre", out0, 2);
    chk("both_pre_h", hc0, 2);
    @(negedge clock);
    op = ADD;
    in = 3;
    en = 1'b1;
    undo = 1'b1;
    @(negedge clock);
    chk("both_out", out0, 1);
    chk("both_h", hc0, 1);
    chk("both_c", carry0, 0);
    @(negedge clock);
    chk("held_out", out0, 1);
    chk("held_h", hc0, 1);
    en = 1'b0;
    undo = 1'b0;

    press(LD, 4);
    press(ADD, 5);
    chk("r_pre", out0, 9);
    chk("r_pre_h", hc0, 3);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("r_out", out0, 0);
    chk("r_zero", zero0, 1);
    chk("r_h", hc0, 0);
    #1 reset = 1'b0;
    pundo();
    chk("r_undo", out0, 0);
    chk("r_undo_h", hc0, 0);
    chk("r_undo_z", zero0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
